// File: rtl/spi_packet_rx.sv
// spi_packet_rx: SPI Mode 0 frame receiver with header/checksum validation and an accepted-frame FIFO
module spi_packet_rx #(
  parameter int          PACKET_BYTES = 16,
  parameter logic [7:0]  HEADER_BYTE  = 8'hAA,
  parameter bit          CHECK_MODE   = 1'b0,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs_n,
  input  logic                      sck,
  input  logic                      sdi,
  output logic [8*PACKET_BYTES-1:0] pkt_data,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic                      initialized,
  output logic                      error,
  output logic [1:0]                err_code,
  output logic [15:0]               good_cnt,
  output logic [15:0]               err_cnt
);
  localparam int NB = 8 * PACKET_BYTES;
  localparam int CW = $clog2(NB + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, SHIFT, EVAL} state_t;
  state_t state, nxt;
  logic [2:0] cs_q, sck_q;
  logic [1:0] sdi_q, live;
  logic armed, fall_seen, cs_fall, cs_rise, sck_rise, go;
  logic [NB-1:0] shreg;
  logic [CW-1:0] bitcnt;
  logic [7:0] xsum;
  logic len_bad, hdr_bad, full, pop, push, eval;
  logic [1:0] code;
  logic [NB-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  // a falling edge counts only once cs_n has been seen genuinely high since reset
  assign go = armed & (cs_fall | (fall_seen & ~cs_q[1]));
  // synchronizers, edge-detect history and the re-arm tracker for frames in flight at reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q  <= 3'b111;
      sck_q <= 3'b000;
      sdi_q <= 2'b00;
      live  <= 2'b00;
      armed <= 1'b0;
    end else begin
      cs_q  <= {cs_q[1:0], cs_n};
      sck_q <= {sck_q[1:0], sck};
      sdi_q <= {sdi_q[0], sdi};
      live  <= {live[0], 1'b1};
      armed <= armed | (live[1] & cs_q[1]);
    end
  end
  // state register plus memory of a cs_n fall that landed in EVAL
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fall_seen <= 1'b0;
    end else begin
      state     <= nxt;
      fall_seen <= (state == EVAL) & cs_fall;
    end
  end
  // next-state logic
  always_comb begin
    nxt = state == IDLE  ? (go ? SHIFT : IDLE) :
          state == SHIFT ? (cs_rise ? EVAL : SHIFT) : IDLE;
  end
  // MSB-first shifter; counter stops at one past a full frame so overlong frames are caught
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && go)) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (state == SHIFT && sck_rise && bitcnt <= CW'(NB)) begin
      if (bitcnt != CW'(NB)) shreg <= {shreg[NB-2:0], sdi_q[1]};
      bitcnt <= bitcnt + CW'(1);
    end
  end
  // XOR over every byte is zero exactly when the trailer matches the XOR of the others
  always_comb begin
    xsum = '0;
    for (int i = 0; i < PACKET_BYTES; i++) xsum = xsum ^ shreg[8*i +: 8];
  end
  // frame evaluation outputs
  always_comb begin
    eval    = state == EVAL;
    pop     = pkt_valid & pkt_ready;
    full    = (wptr - rptr) == (AW+1)'(FIFO_DEPTH);
    len_bad = bitcnt != CW'(NB);
    hdr_bad = shreg[NB-1 -: 8] != HEADER_BYTE || (CHECK_MODE && xsum != 8'h00);
    code    = len_bad ? 2'd1 : hdr_bad ? 2'd2 : (full & ~pop) ? 2'd3 : 2'd0;
    push    = eval & (code == 2'd0);
  end
  // status and saturating counters, updated only on EVAL
  always_ff @(posedge clk) begin
    if (reset) begin
      initialized <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'd0;
      good_cnt    <= '0;
      err_cnt     <= '0;
    end else if (eval) begin
      initialized <= code == 2'd0;
      error       <= code != 2'd0;
      err_code    <= code;
      if (code == 2'd0 && ~&good_cnt) good_cnt <= good_cnt + 16'd1;
      if (code != 2'd0 && ~&err_cnt) err_cnt <= err_cnt + 16'd1;
    end
  end
  // FIFO storage; on full with simultaneous pop the write reuses the slot being freed
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= shreg;
  end
  // FIFO pointers with wrap bit
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end
  assign pkt_valid = wptr != rptr;
  assign pkt_data  = mem[rptr[AW-1:0]];
endmodule

// File: tb/tb_spi_packet_rx.sv
// tb_spi_packet_rx: scenario tests for spi_packet_rx with a frame scoreboard
module tb_spi_packet_rx;
  logic clk = 1'b0, reset, cs_s, sck_s, sdi_s, sel, rdy;
  logic cs_n0, sck0, cs_n1, sck1, pr0, pr1;
  logic [127:0] pkt_data0;
  logic [31:0] pkt_data1;
  logic pkt_valid0, init0, error0, pkt_valid1, init1, error1;
  logic [1:0] err_code0, err_code1;
  logic [15:0] good0, errc0, good1, errc1;
  logic [7:0] fb [80];
  logic [127:0] sb [$];
  logic [127:0] exp_f;
  int checks = 0, errors = 0, exp_good = 0, exp_err = 0;
  always #5 clk = ~clk;
  assign cs_n0 = sel | cs_s;
  assign sck0  = ~sel & sck_s;
  assign cs_n1 = ~sel | cs_s;
  assign sck1  = sel & sck_s;
  assign pr0   = rdy & ~sel;
  assign pr1   = rdy & sel;
  spi_packet_rx u0 (
    .clk(clk), .reset(reset), .cs_n(cs_n0), .sck(sck0), .sdi(sdi_s),
    .pkt_data(pkt_data0), .pkt_valid(pkt_valid0), .pkt_ready(pr0),
    .initialized(init0), .error(error0), .err_code(err_code0),
    .good_cnt(good0), .err_cnt(errc0)
  );
  spi_packet_rx #(.PACKET_BYTES(4), .CHECK_MODE(1'b1)) u1 (
    .clk(clk), .reset(reset), .cs_n(cs_n1), .sck(sck1), .sdi(sdi_s),
    .pkt_data(pkt_data1), .pkt_valid(pkt_valid1), .pkt_ready(pr1),
    .initialized(init1), .error(error1), .err_code(err_code1),
    .good_cnt(good1), .err_cnt(errc1)
  );
  function automatic logic [127:0] pack16();
    logic [127:0] v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], fb[i]};
    return v;
  endfunction
  task automatic half();
    repeat (3) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    sdi_s = b;
    half();
    sck_s = 1'b1;
    half();
    sck_s = 1'b0;
  endtask
  task automatic send_frame(input int nbytes);
    cs_s = 1'b0;
    half();
    for (int i = 0; i < nbytes; i++)
      for (int b = 7; b >= 0; b--) send_bit(fb[i][b]);
    half();
    cs_s = 1'b1;
  endtask
  task automatic finish_frame(input bit pop_eval);
    repeat (3) @(posedge clk);
    #1;
    if (pop_eval) begin
      exp_f = sb.pop_front();
      checks++;
      if (pkt_data0 !== exp_f) begin errors++; $display("FAIL eval_pop_data got %h want %h", pkt_data0, exp_f); end
      rdy = 1'b1;
    end
    @(posedge clk);
    #1;
    rdy = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic pop_check(input string nm);
    @(negedge clk);
    exp_f = sb.pop_front();
    checks++;
    if (pkt_valid0 !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", nm, pkt_valid0); end
    checks++;
    if (pkt_data0 !== exp_f) begin errors++; $display("FAIL %s_data got %h want %h", nm, pkt_data0, exp_f); end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask
  task automatic rand_frame();
    fb[0] = 8'hAA;
    for (int i = 1; i < 16; i++) fb[i] = 8'($urandom);
  endtask
  task automatic check_counts(input string nm);
    checks++;
    if (good0 !== 16'(exp_good)) begin errors++; $display("FAIL %s_good got %0d want %0d", nm, good0, exp_good); end
    checks++;
    if (errc0 !== 16'(exp_err)) begin errors++; $display("FAIL %s_errcnt got %0d want %0d", nm, errc0, exp_err); end
  endtask
  task automatic test_reset();
    checks++;
    if (pkt_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pkt_valid0); end
    checks++;
    if (init0 !== 1'b0) begin errors++; $display("FAIL reset_init got %b want 0", init0); end
    checks++;
    if (error0 !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error0); end
    checks++;
    if (err_code0 !== 2'd0) begin errors++; $display("FAIL reset_code got %0d want 0", err_code0); end
    check_counts("reset");
  endtask
  task automatic test_latency();
    for (int i = 0; i < 16; i++) fb[i] = 8'(i);
    fb[0] = 8'hAA;
    sb.push_back(pack16());
    send_frame(16);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pkt_valid0 !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", pkt_valid0); end
    @(posedge clk);
    #1;
    checks++;
    if (pkt_valid0 !== 1'b1) begin errors++; $display("FAIL lat_valid got %b want 1", pkt_valid0); end
    checks++;
    if (pkt_data0[127:120] !== 8'hAA) begin errors++; $display("FAIL lat_byte0 got %h want aa", pkt_data0[127:120]); end
    checks++;
    if (pkt_data0[7:0] !== 8'h0F) begin errors++; $display("FAIL lat_byte15 got %h want 0f", pkt_data0[7:0]); end
    checks++;
    if (init0 !== 1'b1) begin errors++; $display("FAIL lat_init got %b want 1", init0); end
    exp_good++;
    check_counts("lat");
    repeat (4) @(negedge clk);
    pop_check("lat_pop");
  endtask
  task automatic test_length();
    for (int i = 0; i < 17; i++) fb[i] = 8'(i + 1);
    fb[0] = 8'hAA;
    send_frame(15);
    finish_frame(1'b0);
    exp_err++;
    checks++;
    if (err_code0 !== 2'd1) begin errors++; $display("FAIL len15_code got %0d want 1", err_code0); end
    checks++;
    if (error0 !== 1'b1 || init0 !== 1'b0) begin errors++; $display("FAIL len15_status got %b%b want 10", error0, init0); end
    send_frame(17);
    finish_frame(1'b0);
    exp_err++;
    checks++;
    if (err_code0 !== 2'd1) begin errors++; $display("FAIL len17_code got %0d want 1", err_code0); end
    checks++;
    if (pkt_valid0 !== 1'b0) begin errors++; $display("FAIL len_valid got %b want 0", pkt_valid0); end
    check_counts("len");
  endtask
  task automatic test_checksum();
    sel = 1'b1;
    fb[0] = 8'hAA; fb[1] = 8'h12; fb[2] = 8'h34; fb[3] = 8'h8C;
    send_frame(4);
    finish_frame(1'b0);
    checks++;
    if (init1 !== 1'b1 || pkt_valid1 !== 1'b1) begin errors++; $display("FAIL cs_ok got init %b valid %b want 1 1", init1, pkt_valid1); end
    checks++;
    if (pkt_data1 !== 32'hAA12348C) begin errors++; $display("FAIL cs_data got %h want aa12348c", pkt_data1); end
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    fb[3] = 8'h00;
    send_frame(4);
    finish_frame(1'b0);
    checks++;
    if (err_code1 !== 2'd2 || error1 !== 1'b1) begin errors++; $display("FAIL cs_bad got code %0d err %b want 2 1", err_code1, error1); end
    checks++;
    if (pkt_valid1 !== 1'b0 || good1 !== 16'd1 || errc1 !== 16'd1) begin errors++; $display("FAIL cs_state got v%b g%0d e%0d want v0 g1 e1", pkt_valid1, good1, errc1); end
    sel = 1'b0;
  endtask
  task automatic test_overflow();
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      if (f < 2) begin sb.push_back(pack16()); exp_good++; end
      else exp_err++;
      send_frame(16);
      finish_frame(1'b0);
    end
    checks++;
    if (err_code0 !== 2'd3 || error0 !== 1'b1) begin errors++; $display("FAIL ovf_code got %0d err %b want 3 1", err_code0, error0); end
    check_counts("ovf");
    pop_check("ovf_pop1");
    pop_check("ovf_pop2");
  endtask
  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      exp_good++;
      send_frame(16);
      finish_frame(f == 2);
      sb.push_back(pack16());
    end
    checks++;
    if (error0 !== 1'b0 || err_code0 !== 2'd0) begin errors++; $display("FAIL fullpop_status got err %b code %0d want 0 0", error0, err_code0); end
    check_counts("fullpop");
    pop_check("fullpop1");
    pop_check("fullpop2");
    @(negedge clk);
    checks++;
    if (pkt_valid0 !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b want 0", pkt_valid0); end
  endtask
  task automatic test_reset_mid();
    rand_frame();
    cs_s = 1'b0;
    half();
    for (int i = 0; i < 40; i++) send_bit(fb[i / 8][7 - i % 8]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_good = 0;
    exp_err = 0;
    sb.delete();
    for (int i = 40; i < 128; i++) send_bit(fb[i / 8][7 - i % 8]);
    half();
    cs_s = 1'b1;
    finish_frame(1'b0);
    check_counts("rmid_ignored");
    checks++;
    if (pkt_valid0 !== 1'b0 || init0 !== 1'b0) begin errors++; $display("FAIL rmid_state got v%b i%b want 0 0", pkt_valid0, init0); end
    rand_frame();
    sb.push_back(pack16());
    exp_good++;
    send_frame(16);
    finish_frame(1'b0);
    check_counts("rmid_next");
    pop_check("rmid_pop");
  endtask
  initial begin
    reset = 1'b1; cs_s = 1'b1; sck_s = 1'b0; sdi_s = 1'b0; sel = 1'b0; rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    repeat (4) @(negedge clk);
    test_latency();
    test_length();
    test_checksum();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_packet_rx.md
SPI_PACKET_RX -- requirements
Module: spi_packet_rx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PACKET_BYTES, 16: bytes per frame, 2..64
- HEADER_BYTE, 8'hAA: required value of byte 0
- CHECK_MODE, 0: 0 = no checksum; 1 = byte PACKET_BYTES-1 is XOR of bytes 0..PACKET_BYTES-2
- FIFO_DEPTH, 2: accepted-frame queue depth, power of 2, >=2
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: system clock; sole clock, every flop on its rising edge
- reset, in, 1: synchronous, active-high
- cs_n, in, 1: SPI chip select, active low, asynchronous
- sck, in, 1: SPI clock, Mode 0, asynchronous
- sdi, in, 1: MOSI, asynchronous
- pkt_data, out, 8*PACKET_BYTES: FIFO head frame; byte 0 at MSBs, byte i at [8*(PACKET_BYTES-i)-1 -: 8]
- pkt_valid, out, 1: FIFO non-empty
- pkt_ready, in, 1: consumer pop strobe
- initialized, out, 1: most recent frame accepted
- error, out, 1: most recent frame rejected
- err_code, out, 2: last rejection cause (0 none, 1 length, 2 header/checksum, 3 overflow)
- good_cnt, out, 16: accepted-frame count
- err_cnt, out, 16: rejected-frame count

Function
REQ-003 cs_n, sck and sdi each pass through a 2-flop synchronizer before use; a third flop on cs_n and sck provides edge detection.
REQ-004 clk frequency shall be >= 4x sck frequency; behaviour outside this limit is undefined.
REQ-005 FSM states: IDLE, SHIFT, EVAL.
REQ-006 IDLE -> SHIFT only on a synchronized cs_n falling edge; this clears the shift register and bit counter.
REQ-007 In SHIFT, each synchronized sck rising edge shifts the synchronized sdi into the LSB (MSB-first) and increments the bit counter.
REQ-008 The bit counter saturates at 8*PACKET_BYTES+1; once 8*PACKET_BYTES bits are held, further sck edges do not shift.
REQ-009 SHIFT -> EVAL on a synchronized cs_n rising edge; EVAL -> IDLE unconditionally after one cycle.
REQ-010 EVAL checks in priority order:
- bit count != 8*PACKET_BYTES -> length error (code 1)
- byte 0 != HEADER_BYTE, or CHECK_MODE=1 and checksum mismatch -> code 2
- FIFO full and no pop in the same cycle -> overflow (code 3), frame dropped
- otherwise -> frame pushed
REQ-011 Zero-bit frame (cs_n pulse with no sck) counts as a length error.
REQ-012 Accepted frame: initialized=1, error=0, err_code=0, good_cnt+1.
REQ-013 Rejected frame: initialized=0, error=1, err_code set per REQ-010, err_cnt+1.
REQ-014 good_cnt and err_cnt saturate at 16'hFFFF.
REQ-015 Status outputs hold their values between EVAL cycles.
REQ-016 Pop occurs when pkt_valid && pkt_ready.
REQ-017 A push and a pop in the same cycle are both performed, including when the FIFO is full; occupancy is unchanged.
REQ-018 pkt_data is stable while pkt_valid=1 and no pop occurs; its value is don't-care when pkt_valid=0.
REQ-019 Latency: a cs_n rising edge at the input produces pkt_valid=1 (FIFO previously empty) at the 4th subsequent clk rising edge: sync1, sync2, edge-detect/enter EVAL, push.
REQ-020 A cs_n falling edge during EVAL is detected in IDLE on the next cycle, provided the synchronized cs_n is still low at that point.

Reset
REQ-021 reset=1 on a clk edge sets the FSM to IDLE and clears the shift register, bit counter and FIFO pointers; pkt_valid=0, initialized=0, error=0, err_code=0, good_cnt=0, err_cnt=0.
REQ-022 Synchronizer flops reset to cs_n=1 and sck=0.
REQ-023 After reset deasserts with cs_n already low, the in-progress frame is ignored; reception resumes only after a cs_n high-then-low sequence.

Verification
REQ-024 Defaults, CHECK_MODE=0, 16-byte frame AA 01 02 .. 0F, pkt_ready=0 -> pkt_valid=1 at 4th clk after cs_n rises; pkt_data[127:120]=8'hAA, pkt_data[7:0]=8'h0F; initialized=1; good_cnt=1.
REQ-025 Frame of 15 bytes, then frame of 17 bytes -> both rejected; err_code=1, err_cnt=2, pkt_valid=0, frame-1 status replaced.
REQ-026 CHECK_MODE=1, PACKET_BYTES=4, frame AA 12 34 8C -> accepted; frame AA 12 34 00 -> err_code=2, error=1.
REQ-027 Three valid frames, pkt_ready=0, FIFO_DEPTH=2 -> third frame dropped with err_code=3, good_cnt=2, err_cnt=1; then two pops return frames 1 and 2 in order.
REQ-028 FIFO full with pkt_ready=1 held during the EVAL cycle of a third frame -> no overflow; good_cnt=3; occupancy stays 2.
REQ-029 reset pulsed mid-frame after 40 bits with cs_n still low -> remaining bits ignored, no count change at cs_n rise; next complete frame accepted.
